// File: rtl/duration_meter.sv
// duration_meter
//   Measures how many clk cycles an active-low window on glitch_n stays low.
//   It sits on the loopback/monitor path, so the host can confirm that a
//   requested glitch duration actually appeared on the pin. A one-cycle arm
//   starts one measurement. The result is held behind a valid/ack handshake.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   arm       one-cycle pulse that starts a measurement (honoured in IDLE only)
//   ack       consumer accepts the result and clears valid
//   glitch_n  monitored active-low window, asynchronous to clk
//   width     measured low duration in clk cycles (0 on timeout)
//   valid     result available, from capture until ack
//   overflow  counter saturated during the captured measurement
//   timeout   no falling edge arrived within TIMEOUT cycles of arming
//   busy      high while armed, waiting for an edge or measuring
module duration_meter #(
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TIMEOUT     = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             ack,
    input  logic             glitch_n,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             overflow,
    output logic             timeout,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_FALL,
        MEASURE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s;
    logic                   s_d;
    logic [CNT_W-1:0]       count;
    logic                   ovf_int;
    logic [31:0]            wait_timer;

    // Saturating increment: the counter parks at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

    // The timer counts from 0 after arming. It therefore hits TIMEOUT-1 on the
    // TIMEOUT-th waiting cycle. A TIMEOUT of 0 means "wait forever".
    function automatic logic wait_expired(input logic [31:0] timer);
        return (TIMEOUT != 32'd0) && (timer == TIMEOUT - 32'd1);
    endfunction

    assign s = sync_ff[SYNC_STAGES-1];

    // Synchroniser stage boundary. Reset to the inactive (high) level so that
    // leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff <= '1;
            s_d     <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], glitch_n};
            s_d     <= s;
        end
    end

    // Measurement FSM stage boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            width      <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            count      <= '0;
            ovf_int    <= 1'b0;
            wait_timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state      <= ARMED;
                        busy       <= 1'b1;
                        count      <= '0;
                        ovf_int    <= 1'b0;
                        wait_timer <= '0;
                    end
                end
                // The line must be seen high before an edge is accepted. This
                // keeps a window that is already in progress from being measured.
                ARMED: begin
                    if (wait_expired(wait_timer)) begin
                        state    <= DONE;
                        width    <= '0;
                        timeout  <= 1'b1;
                        overflow <= 1'b0;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        wait_timer <= wait_timer + 32'd1;
                        if (s) begin
                            state <= WAIT_FALL;
                        end
                    end
                end
                WAIT_FALL: begin
                    if (s_d && !s) begin
                        // The edge cycle is itself the first low cycle.
                        state <= MEASURE;
                        count <= CNT_W'(1);
                    end else if (wait_expired(wait_timer)) begin
                        state    <= DONE;
                        width    <= '0;
                        timeout  <= 1'b1;
                        overflow <= 1'b0;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        wait_timer <= wait_timer + 32'd1;
                    end
                end
                MEASURE: begin
                    if (!s) begin
                        count <= sat_inc(count);
                        if (count == CNT_MAX) begin
                            ovf_int <= 1'b1;
                        end
                    end else begin
                        state    <= DONE;
                        width    <= count;
                        overflow <= ovf_int;
                        timeout  <= 1'b0;
                        valid    <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duration_meter.sv
// Testbench for duration_meter. Two instances share the same stimulus: one is
// 32 bits wide and one is 4 bits wide, and both use TIMEOUT=100. The stimulus
// pushes the expected results into per-instance queues. A monitor pops an entry
// and compares it each time that instance raises valid.
module tb_duration_meter;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        ack = 1'b0;
    logic        glitch_n = 1'b1;

    logic [31:0] width_m;
    logic        valid_m, ovf_m, to_m, busy_m;
    logic [3:0]  width_s;
    logic        valid_s, ovf_s, to_s, busy_s;

    always #5 clk = ~clk;

    duration_meter #(.CNT_W(32), .SYNC_STAGES(SYNC), .TIMEOUT(32'd100)) dut (
        .clk(clk), .reset(reset), .arm(arm), .ack(ack), .glitch_n(glitch_n),
        .width(width_m), .valid(valid_m), .overflow(ovf_m), .timeout(to_m), .busy(busy_m)
    );

    duration_meter #(.CNT_W(4), .SYNC_STAGES(SYNC), .TIMEOUT(32'd100)) dut_small (
        .clk(clk), .reset(reset), .arm(arm), .ack(ack), .glitch_n(glitch_n),
        .width(width_s), .valid(valid_s), .overflow(ovf_s), .timeout(to_s), .busy(busy_s)
    );

    typedef struct packed {
        logic [31:0] w;
        logic        o;
        logic        t;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t e_m, e_s;
    int   checks = 0;
    int   errors = 0;
    logic pv_m = 1'b0;
    logic pv_s = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitors: compare on each rising edge of valid, sampling at the falling clock edge
    always @(negedge clk) begin
        if (valid_m && !pv_m) begin
            if (q_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_unexpected_result: width %0d with nothing expected", width_m);
            end else begin
                e_m = q_m.pop_front();
                check("main_width", width_m, e_m.w);
                check("main_overflow", {31'd0, ovf_m}, {31'd0, e_m.o});
                check("main_timeout", {31'd0, to_m}, {31'd0, e_m.t});
            end
        end
        pv_m <= valid_m;
    end

    always @(negedge clk) begin
        if (valid_s && !pv_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL small_unexpected_result: width %0d with nothing expected", width_s);
            end else begin
                e_s = q_s.pop_front();
                check("small_width", {28'd0, width_s}, e_s.w);
                check("small_overflow", {31'd0, ovf_s}, {31'd0, e_s.o});
                check("small_timeout", {31'd0, to_s}, {31'd0, e_s.t});
            end
        end
        pv_s <= valid_s;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_clears_valid_main", {31'd0, valid_m}, 32'd0);
        check("ack_clears_valid_small", {31'd0, valid_s}, 32'd0);
    endtask

    // Arm, let the line settle high, then drive one low window of len cycles.
    task automatic run_pulse(input int len, input logic [31:0] ws, input logic os);
        pulse_arm();
        tick(3);
        check("busy_waiting", {31'd0, busy_m}, 32'd1);
        q_m.push_back('{w: len, o: 1'b0, t: 1'b0});
        q_s.push_back('{w: ws, o: os, t: 1'b0});
        glitch_n = 1'b0;
        tick(len);
        glitch_n = 1'b1;
        tick(SYNC);
        check("latency_not_early", {31'd0, valid_m}, 32'd0);
        tick();
        check("latency_valid_main", {31'd0, valid_m}, 32'd1);
        check("latency_valid_small", {31'd0, valid_s}, 32'd1);
        check("busy_done", {31'd0, busy_m}, 32'd0);
        pulse_arm();
        check("arm_in_done_ignored", {31'd0, valid_m}, 32'd1);
        check("arm_in_done_not_busy", {31'd0, busy_m}, 32'd0);
        do_ack();
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        check("reset_width", width_m, 32'd0);
        check("reset_valid", {31'd0, valid_m}, 32'd0);
        check("reset_overflow", {31'd0, ovf_m}, 32'd0);
        check("reset_timeout", {31'd0, to_m}, 32'd0);
        check("reset_busy", {31'd0, busy_m}, 32'd0);
        reset = 1'b1;
        tick(2);

        // A generator loaded with din=5 produces a 6-cycle low window
        run_pulse(6, 32'd6, 1'b0);
        // Minimum pulse, then a long one (saturates the 4-bit instance)
        run_pulse(1, 32'd1, 1'b0);
        run_pulse(1000, 32'd15, 1'b1);

        // Armed while low: the window already in progress must be rejected
        glitch_n = 1'b0;
        tick(3);
        pulse_arm();
        check("armed_low_busy", {31'd0, busy_m}, 32'd1);
        tick(9);
        glitch_n = 1'b1;
        tick(4);
        check("armed_low_no_result", {31'd0, valid_m}, 32'd0);
        q_m.push_back('{w: 32'd4, o: 1'b0, t: 1'b0});
        q_s.push_back('{w: 32'd4, o: 1'b0, t: 1'b0});
        glitch_n = 1'b0;
        tick(4);
        glitch_n = 1'b1;
        tick(SYNC + 1);
        check("armed_low_valid", {31'd0, valid_m}, 32'd1);
        do_ack();
        tick(2);

        // Timeout: no falling edge within 100 cycles of arming
        q_m.push_back('{w: 32'd0, o: 1'b0, t: 1'b1});
        q_s.push_back('{w: 32'd0, o: 1'b0, t: 1'b1});
        pulse_arm();
        tick(99);
        check("timeout_not_early", {31'd0, valid_m}, 32'd0);
        tick();
        check("timeout_valid", {31'd0, valid_m}, 32'd1);
        check("timeout_busy", {31'd0, busy_m}, 32'd0);
        do_ack();
        tick(2);

        // Overflow on the 4-bit instance, then a clean result that clears it
        run_pulse(20, 32'd15, 1'b1);
        run_pulse(3, 32'd3, 1'b0);

        // Reset mid-measurement aborts immediately
        pulse_arm();
        tick(3);
        glitch_n = 1'b0;
        tick(5);
        check("measure_busy", {31'd0, busy_m}, 32'd1);
        reset = 1'b0;
        #1;
        check("abort_valid", {31'd0, valid_m}, 32'd0);
        check("abort_busy", {31'd0, busy_m}, 32'd0);
        check("abort_width_main", width_m, 32'd0);
        check("abort_width_small", {28'd0, width_s}, 32'd0);
        glitch_n = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        run_pulse(8, 32'd8, 1'b0);

        tick(5);
        check("queue_main_drained", q_m.size(), 32'd0);
        check("queue_small_drained", q_s.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
